// File: rtl/aska_npg_pkg.sv
// aska_npg_pkg: shared widths, register addresses and commit FSM states for
// the NPG configuration front end (aska_npg_cfg) and its ramp divider.
package aska_npg_pkg;

    localparam int AMP_W   = 6;
    localparam int FREQ_W  = 12;
    localparam int RF_W    = 10;
    localparam int PD_W    = 3;
    localparam int RAMP_W  = 6;
    localparam int ON_W    = 8;
    localparam int OFF_W   = 10;
    localparam int EL_W    = 3;
    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;

    localparam logic [3:0] ADDR_AMP  = 4'd0;
    localparam logic [3:0] ADDR_FREQ = 4'd1;
    localparam logic [3:0] ADDR_PD   = 4'd2;
    localparam logic [3:0] ADDR_RAMP = 4'd3;
    localparam logic [3:0] ADDR_ON   = 4'd4;
    localparam logic [3:0] ADDR_OFF  = 4'd5;
    localparam logic [3:0] ADDR_ELEC = 4'd6;
    localparam logic [3:0] ADDR_CTRL = 4'd7;

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_DIV  = 2'd1,
        CFG_WAIT = 2'd2,
        CFG_LOAD = 2'd3
    } cfg_state_t;

    // Addresses 8-15 have no register behind them.
    function automatic logic addr_is_mapped(input logic [3:0] addr);
        return !addr[3];
    endfunction

endpackage

// File: rtl/aska_npg_rdiv.sv
// aska_npg_rdiv: 10-by-6-bit sequential restoring divider producing ramp_factor,
// one quotient bit per clk, with the zero and minimum-of-one result rules applied.
module aska_npg_rdiv
    import aska_npg_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [RF_W-1:0]   dividend_i,
    input  logic [AMP_W-1:0]  divisor_i,
    output logic              done_o,
    output logic [RF_W-1:0]   quotient_o
);

    localparam logic [3:0] LAST_STEP = 4'(RF_W - 1);

    logic [RF_W-1:0]  quo_q;
    logic [AMP_W-1:0] rem_q;
    logic [AMP_W-1:0] dvs_q;
    logic [3:0]       cnt_q;
    logic             run_q;
    logic             zero_q;

    logic [AMP_W:0]   rem_shift;
    logic             fits;
    logic [AMP_W-1:0] rem_d;

    // Remainder stays below the divisor, so the low bits of the subtraction are exact.
    assign rem_shift = {rem_q, quo_q[RF_W-1]};
    assign fits      = (rem_shift >= {1'b0, dvs_q});
    assign rem_d     = fits ? (rem_shift[AMP_W-1:0] - dvs_q) : rem_shift[AMP_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            zero_q <= (dividend_i == '0) || (divisor_i == '0);
        end else if (run_q) begin
            if (!zero_q) begin
                quo_q <= {quo_q[RF_W-2:0], fits};
                rem_q <= rem_d;
            end
            if (cnt_q == LAST_STEP) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // done marks the cycle of the final step; the quotient is valid from the next cycle.
    assign done_o     = run_q && (cnt_q == LAST_STEP);
    assign quotient_o = zero_q ? '0 : ((quo_q == '0) ? RF_W'(1) : quo_q);

endmodule

// File: rtl/aska_npg_cfg.sv
// aska_npg_cfg: SPI-slave configuration front end that stages NPG parameters and
// loads them atomically between pulses. SPI readback: ASKA_NPG_CFG_READBACK_EN.
module aska_npg_cfg
    import aska_npg_pkg::*;
#(
    parameter int unsigned FREQ_RST    = 400,
    parameter int unsigned PD_RST      = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sclk,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    input  logic              pulse_active,
    output logic [AMP_W-1:0]  amplitude,
    output logic [FREQ_W-1:0] freq,
    output logic [PD_W-1:0]   phaseDuration,
    output logic [RAMP_W-1:0] ramp,
    output logic [RF_W-1:0]   ramp_factor,
    output logic [ON_W-1:0]   ON_time,
    output logic [OFF_W-1:0]  OFF_time,
    output logic [EL_W-1:0]   electrode1,
    output logic [EL_W-1:0]   electrode2,
    output logic              enable,
    output logic              busy,
    output logic              cfg_err
);

    // ---------------- SPI input synchronisation ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   csn_prev_q;
    logic                   sclk_s;
    logic                   csn_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   csn_rise;
    logic                   csn_fall;

    // csn resets high so leaving reset with the bus idle creates no edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    // ---------------- Frame capture and decode ----------------
    logic [FRAME_W-1:0] shift_q;
    logic [4:0]         bit_cnt_q;
    logic               cfg_err_q;
    logic               busy_q;

    logic               frame_ok;
    logic [3:0]         frame_addr;
    logic [DATA_W-1:0]  frame_data;
    logic               is_ctrl;
    logic               wr_stage;
    logic               wr_ctrl;
    logic               commit_req;
    logic               commit_go;
    logic               err_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (csn_rise || csn_fall) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise && !csn_s) begin
                shift_q   <= {shift_q[FRAME_W-2:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            cfg_err_q <= err_d;
        end
    end

    assign frame_ok   = csn_rise && (bit_cnt_q == 5'd16);
    assign frame_addr = shift_q[FRAME_W-1:DATA_W];
    assign frame_data = shift_q[DATA_W-1:0];
    assign is_ctrl    = (frame_addr == ADDR_CTRL);
    assign wr_stage   = frame_ok && addr_is_mapped(frame_addr) && !is_ctrl && !busy_q;
    assign wr_ctrl    = frame_ok && is_ctrl;
    assign commit_req = wr_ctrl && frame_data[1];
    assign commit_go  = commit_req && !busy_q;

    assign err_d = (csn_rise && (bit_cnt_q != 5'd16))
                 || (frame_ok && !addr_is_mapped(frame_addr))
                 || (frame_ok && addr_is_mapped(frame_addr) && !is_ctrl && busy_q)
                 || (commit_req && busy_q);

    // ---------------- Staging registers ----------------
    logic [AMP_W-1:0]  stg_amp_q;
    logic [FREQ_W-1:0] stg_freq_q;
    logic [PD_W-1:0]   stg_pd_q;
    logic [RAMP_W-1:0] stg_ramp_q;
    logic [ON_W-1:0]   stg_on_q;
    logic [OFF_W-1:0]  stg_off_q;
    logic [EL_W-1:0]   stg_el1_q;
    logic [EL_W-1:0]   stg_el2_q;
    logic              stg_en_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_amp_q  <= '0;
            stg_freq_q <= FREQ_W'(FREQ_RST);
            stg_pd_q   <= PD_W'(PD_RST);
            stg_ramp_q <= '0;
            stg_on_q   <= '0;
            stg_off_q  <= '0;
            stg_el1_q  <= '0;
            stg_el2_q  <= '0;
            stg_en_q   <= 1'b0;
        end else begin
            if (wr_stage) begin
                case (frame_addr)
                    ADDR_AMP:  stg_amp_q  <= frame_data[AMP_W-1:0];
                    ADDR_FREQ: stg_freq_q <= frame_data[FREQ_W-1:0];
                    ADDR_PD:   stg_pd_q   <= frame_data[PD_W-1:0];
                    ADDR_RAMP: stg_ramp_q <= frame_data[RAMP_W-1:0];
                    ADDR_ON:   stg_on_q   <= frame_data[ON_W-1:0];
                    ADDR_OFF:  stg_off_q  <= frame_data[OFF_W-1:0];
                    ADDR_ELEC: begin
                        stg_el1_q <= frame_data[EL_W-1:0];
                        stg_el2_q <= frame_data[2*EL_W-1:EL_W];
                    end
                    default: ;
                endcase
            end
            if (wr_ctrl) begin
                stg_en_q <= frame_data[0];
            end
        end
    end

    // ---------------- Ramp divider ----------------
    logic            div_done;
    logic [RF_W-1:0] div_quot;

    aska_npg_rdiv u_rdiv (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (commit_go),
        .dividend_i ({stg_amp_q, 4'b0000}),
        .divisor_i  (stg_ramp_q),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    // ---------------- Commit FSM and NPG output registers ----------------
    cfg_state_t        state_q;
    logic [AMP_W-1:0]  amp_q;
    logic [FREQ_W-1:0] freq_q;
    logic [PD_W-1:0]   pd_q;
    logic [RAMP_W-1:0] ramp_q;
    logic [RF_W-1:0]   rf_q;
    logic [ON_W-1:0]   on_q;
    logic [OFF_W-1:0]  off_q;
    logic [EL_W-1:0]   el1_q;
    logic [EL_W-1:0]   el2_q;
    logic              enable_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= CFG_IDLE;
            busy_q   <= 1'b0;
            amp_q    <= '0;
            freq_q   <= FREQ_W'(FREQ_RST);
            pd_q     <= PD_W'(PD_RST);
            ramp_q   <= '0;
            rf_q     <= '0;
            on_q     <= '0;
            off_q    <= '0;
            el1_q    <= '0;
            el2_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            case (state_q)
                CFG_IDLE: begin
                    if (commit_go) begin
                        state_q <= CFG_DIV;
                        busy_q  <= 1'b1;
                    end
                end
                CFG_DIV: begin
                    if (div_done) begin
                        state_q <= CFG_WAIT;
                    end
                end
                CFG_WAIT: begin
                    if (!pulse_active) begin
                        state_q <= CFG_LOAD;
                    end
                end
                CFG_LOAD: begin
                    amp_q    <= stg_amp_q;
                    freq_q   <= stg_freq_q;
                    pd_q     <= stg_pd_q;
                    ramp_q   <= stg_ramp_q;
                    rf_q     <= div_quot;
                    on_q     <= stg_on_q;
                    off_q    <= stg_off_q;
                    el1_q    <= stg_el1_q;
                    el2_q    <= stg_el2_q;
                    enable_q <= stg_en_q;
                    state_q  <= CFG_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= CFG_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Disabling stimulation must never wait for a commit, even one landing this cycle.
            if (wr_ctrl && !frame_data[0]) begin
                enable_q <= 1'b0;
            end
        end
    end

    assign amplitude     = amp_q;
    assign freq          = freq_q;
    assign phaseDuration = pd_q;
    assign ramp          = ramp_q;
    assign ramp_factor   = rf_q;
    assign ON_time       = on_q;
    assign OFF_time      = off_q;
    assign electrode1    = el1_q;
    assign electrode2    = el2_q;
    assign enable        = enable_q;
    assign busy          = busy_q;
    assign cfg_err       = cfg_err_q;

    // ---------------- Optional SPI readback ----------------
`ifdef ASKA_NPG_CFG_READBACK_EN
    logic [3:0]         rb_addr_q;
    logic [FRAME_W-1:0] rb_shift_q;
    logic [DATA_W-1:0]  rb_value;
    logic               sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_comb begin
        rb_value = '0;
        case (rb_addr_q)
            ADDR_AMP:  rb_value = DATA_W'(amp_q);
            ADDR_FREQ: rb_value = freq_q;
            ADDR_PD:   rb_value = DATA_W'(pd_q);
            ADDR_RAMP: rb_value = DATA_W'(ramp_q);
            ADDR_ON:   rb_value = DATA_W'(on_q);
            ADDR_OFF:  rb_value = DATA_W'(off_q);
            ADDR_ELEC: rb_value = DATA_W'({el2_q, el1_q});
            ADDR_CTRL: rb_value = DATA_W'({busy_q, enable_q});
            default:   rb_value = '0;
        endcase
    end

    // The word is captured at frame start so it cannot tear while shifting out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rb_addr_q  <= '0;
            rb_shift_q <= '0;
        end else begin
            if (csn_fall) begin
                rb_shift_q <= {4'b0000, rb_value};
            end else if (sclk_fall && !csn_s) begin
                rb_shift_q <= {rb_shift_q[FRAME_W-2:0], 1'b0};
            end
            if (frame_ok && addr_is_mapped(frame_addr)) begin
                rb_addr_q <= frame_addr;
            end
        end
    end

    assign miso = ~csn_s & rb_shift_q[FRAME_W-1];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_aska_npg_cfg.sv
// tb_aska_npg_cfg: directed SPI frames against aska_npg_cfg with hand-computed
// expectations checked by immediate assertions.
module tb_aska_npg_cfg;

    logic        clk;
    logic        resetn;
    logic        sclk;
    logic        csn;
    logic        mosi;
    logic        miso;
    logic        pulse_active;
    logic [5:0]  amplitude;
    logic [11:0] freq;
    logic [2:0]  phaseDuration;
    logic [5:0]  ramp;
    logic [9:0]  ramp_factor;
    logic [7:0]  ON_time;
    logic [9:0]  OFF_time;
    logic [2:0]  electrode1;
    logic [2:0]  electrode2;
    logic        enable;
    logic        busy;
    logic        cfg_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int e0;
    int nbusy;
    bit amp_moved;

    aska_npg_cfg dut (
        .clk           (clk),
        .resetn        (resetn),
        .sclk          (sclk),
        .csn           (csn),
        .mosi          (mosi),
        .miso          (miso),
        .pulse_active  (pulse_active),
        .amplitude     (amplitude),
        .freq          (freq),
        .phaseDuration (phaseDuration),
        .ramp          (ramp),
        .ramp_factor   (ramp_factor),
        .ON_time       (ON_time),
        .OFF_time      (OFF_time),
        .electrode1    (electrode1),
        .electrode2    (electrode2),
        .enable        (enable),
        .busy          (busy),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every clock cycle cfg_err is high counts as one pulse.
    always @(negedge clk) begin
        if (cfg_err === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sends the top nbits of w MSB-first, mode 0; returns right after csn rises.
    task automatic spi_bits(input logic [15:0] w, input int nbits);
        $display("spi frame 0x%04h bits %0d", w, nbits);
        csn = 1'b0;
        #40;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        #40 csn = 1'b1;
    endtask

    task automatic spi_write(input logic [3:0] a, input logic [11:0] d);
        spi_bits({a, d}, 16);
        #100;
    endtask

    task automatic wait_busy_high();
        for (int i = 0; i < 40 && busy !== 1'b1; i++) @(negedge clk);
        check("busy_rise", busy, 1);
    endtask

    // Issues a commit and counts cycles busy is high; flags any output change meanwhile.
    task automatic do_commit(input logic [11:0] ctrl, output int n, output bit moved);
        logic [5:0] amp0;
        amp0  = amplitude;
        moved = 1'b0;
        spi_bits({4'd7, ctrl}, 16);
        wait_busy_high();
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            if (amplitude !== amp0) moved = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        resetn = 1'b0; sclk = 1'b0; csn = 1'b1; mosi = 1'b0; pulse_active = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_freq", freq, 400);
        check("rst_pd", phaseDuration, 1);
        check("rst_amp", amplitude, 0);
        check("rst_rf", ramp_factor, 0);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_miso", miso, 0);
        check("rst_err", cfg_err, 0);

        // Basic commit: 40*16/50 = 12.8 -> 12
        spi_write(4'd0, 12'd40);
        spi_write(4'd3, 12'd50);
        do_commit(12'd3, nbusy, amp_moved);
        check("c1_busy_cycles", nbusy, 12);
        check("c1_amp_held", amp_moved, 0);
        check("c1_amp", amplitude, 40);
        check("c1_ramp", ramp, 50);
        check("c1_rf", ramp_factor, 12);
        check("c1_enable", enable, 1);
        check("c1_freq", freq, 400);

        // Commit held off by pulse_active; 20*16/50 = 6.4 -> 6
        pulse_active = 1'b1;
        spi_write(4'd0, 12'd20);
        spi_bits({4'd7, 12'd3}, 16);
        wait_busy_high();
        repeat (30) @(negedge clk);
        check("hold_busy", busy, 1);
        check("hold_amp", amplitude, 40);
        check("hold_rf", ramp_factor, 12);
        pulse_active = 1'b0;
        @(negedge clk);
        check("load_cyc_amp", amplitude, 40);
        check("load_cyc_busy", busy, 1);
        @(negedge clk);
        check("post_amp", amplitude, 20);
        check("post_rf", ramp_factor, 6);
        check("post_busy", busy, 0);

        // Bad frames: short frame, unmapped address, empty csn pulse
        e0 = err_pulses;
        spi_bits({4'd0, 12'd5}, 15);
        #100;
        spi_write(4'd9, 12'h03F);
        check("bad_err2", err_pulses, e0 + 2);
        spi_bits(16'h0000, 0);
        #100;
        check("empty_err", err_pulses, e0 + 3);
        do_commit(12'd3, nbusy, amp_moved);
        check("bad_amp_kept", amplitude, 20);
        check("bad_rf_kept", ramp_factor, 6);
        check("bad_no_err", err_pulses, e0 + 3);

        // Full parameter set; 1*16/63 = 0 -> clamped to 1
        spi_write(4'd0, 12'd1);
        spi_write(4'd3, 12'd63);
        spi_write(4'd1, 12'd1000);
        spi_write(4'd2, 12'd4);
        spi_write(4'd4, 12'd200);
        spi_write(4'd5, 12'd700);
        spi_write(4'd6, 12'o52);
        do_commit(12'd3, nbusy, amp_moved);
        check("p_rf_clamp", ramp_factor, 1);
        check("p_freq", freq, 1000);
        check("p_pd", phaseDuration, 4);
        check("p_on", ON_time, 200);
        check("p_off", OFF_time, 700);
        check("p_el1", electrode1, 2);
        check("p_el2", electrode2, 5);

        // ramp = 0 -> 0, DIV length unchanged
        spi_write(4'd3, 12'd0);
        do_commit(12'd3, nbusy, amp_moved);
        check("r0_rf", ramp_factor, 0);
        check("r0_busy_cycles", nbusy, 12);

        // Largest result: 63*16/1 = 1008
        spi_write(4'd0, 12'd63);
        spi_write(4'd3, 12'd1);
        do_commit(12'd3, nbusy, amp_moved);
        check("max_rf", ramp_factor, 1008);

        // amplitude = 0 -> 0
        spi_write(4'd0, 12'd0);
        spi_write(4'd3, 12'd5);
        do_commit(12'd3, nbusy, amp_moved);
        check("a0_rf", ramp_factor, 0);

        // Safety disable and rejected writes during WAIT; 33*16/5 = 105.6 -> 105
        pulse_active = 1'b1;
        spi_write(4'd0, 12'd33);
        spi_bits({4'd7, 12'd3}, 16);
        wait_busy_high();
        repeat (15) @(negedge clk);
        check("w_enable_before", enable, 1);
        e0 = err_pulses;
        spi_write(4'd7, 12'd0);
        check("w_enable_off", enable, 0);
        check("w_busy", busy, 1);
        spi_write(4'd7, 12'd2);
        spi_write(4'd0, 12'd9);
        check("w_err2", err_pulses, e0 + 2);
        check("w_busy_still", busy, 1);
        pulse_active = 1'b0;
        repeat (3) @(negedge clk);
        check("w_done", busy, 0);
        check("w_enable_load", enable, 0);
        check("w_amp", amplitude, 33);
        check("w_rf", ramp_factor, 105);

        // Reset mid-commit restores reset state including staging
        pulse_active = 1'b1;
        spi_bits({4'd7, 12'd3}, 16);
        wait_busy_high();
        resetn = 1'b0;
        @(negedge clk);
        check("mr_busy", busy, 0);
        check("mr_amp", amplitude, 0);
        check("mr_freq", freq, 400);
        resetn = 1'b1;
        pulse_active = 1'b0;
        @(negedge clk);
        do_commit(12'd3, nbusy, amp_moved);
        check("mr_stg_freq", freq, 400);
        check("mr_stg_pd", phaseDuration, 1);
        check("mr_stg_amp", amplitude, 0);
        check("mr_enable", enable, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aska_npg_cfg.md
Name: aska_npg_cfg

Overview:
SPI-slave configuration front end for the neuromuscular pulse generator (NPG) core, sitting directly upstream of it.
- Receives 16-bit write frames into staging registers.
- On commit, computes ramp_factor with a sequential divider.
- Transfers the whole parameter set atomically to the NPG inputs, only between pulses, so no parameter changes mid-pulse.

Parameters:
FREQ_RST, 400, reset value of freq (50 Hz).
PD_RST, 1, reset value of phaseDuration (50 us).
SYNC_STAGES, 2, synchronizer depth on sclk/csn/mosi (minimum 2).

Ports:
clk  in  1  system clock; must be at least 4x sclk.
resetn  in  1  asynchronous active-low reset.
sclk  in  1  SPI clock, mode 0, asynchronous to clk.
csn  in  1  SPI chip select, active low.
mosi  in  1  SPI data in, MSB first.
miso  out  1  SPI data out (READBACK_EN only; otherwise tied 0).
pulse_active  in  1  from NPG core; high while a pulse phase is driven.
amplitude  out  6  to NPG.
freq  out  12  to NPG.
phaseDuration  out  3  to NPG.
ramp  out  6  to NPG.
ramp_factor  out  10  to NPG.
ON_time  out  8  to NPG.
OFF_time  out  10  to NPG.
electrode1  out  3  to NPG.
electrode2  out  3  to NPG.
enable  out  1  to NPG.
busy  out  1  commit sequence in progress.
cfg_err  out  1  one-cycle pulse on a rejected frame or write.

Behaviour:
- Reset: every output and staging register is 0, except freq and staging freq = FREQ_RST, and phaseDuration and staging PD = PD_RST. miso = 0, busy = 0. FSM is in IDLE.
- Input sampling: sclk, csn and mosi each pass through SYNC_STAGES flops. A rising edge of synchronized sclk while csn is low shifts mosi into a 16-bit shift register and increments a 5-bit bit count.
- Frame decode: on the synchronized csn rising edge, if bit count == 16 the frame decodes as addr = [15:12], data = [11:0]. The staging write lands on the next clk. Bit count clears on every csn edge.
- Bad frame: bit count != 16 means the frame is discarded and cfg_err pulses.
- Register map (data LSB-aligned, upper bits ignored):
  - 0: amplitude[5:0]
  - 1: freq[11:0]
  - 2: phaseDuration[2:0]
  - 3: ramp[5:0]
  - 4: ON_time[7:0]
  - 5: OFF_time[9:0]
  - 6: {electrode2[5:3], electrode1[2:0]}
  - 7: control, bit0 = enable, bit1 = commit
- Unmapped address (8-15): frame discarded, cfg_err pulses.
- Control register writes:
  - bit0 = 0 drives the enable output low on the next clk, immediately, regardless of busy (safety path).
  - bit0 = 1 only sets staging enable; the output rises at LOAD.
  - bit1 = 1 starts a commit. If busy is high, the commit is ignored and cfg_err pulses.
- Writes to addresses 0-6 while busy are dropped and cfg_err pulses.
- Commit FSM:
  - IDLE: leave on an accepted commit. Latch dividend = staging amplitude << 4 (10 bits) and divisor = staging ramp. Go to DIV.
  - DIV: 10-cycle restoring divide, one quotient bit per clk. Then go to WAIT.
  - WAIT: stay while pulse_active = 1. Go to LOAD on the first cycle pulse_active = 0.
  - LOAD: all outputs take their staging values plus the computed ramp_factor in a single cycle, then return to IDLE.
- busy is high throughout DIV, WAIT and LOAD. Minimum commit-to-output latency is 12 clk.
- ramp_factor rules:
  - ramp == 0 gives 0; the divider is skipped but DIV still lasts 10 cycles.
  - amplitude == 0 gives 0.
  - Otherwise ramp_factor = max(1, floor(amplitude*16/ramp)). The maximum is 1008, so it fits in 10 bits.
- Reset mid-frame or mid-commit: return to reset state. The partial frame is lost.
- csn rising with no sclk edges: bit count is 0, so it is a bad frame and cfg_err pulses.

Optional Feature:
Macro ASKA_NPG_CFG_READBACK_EN.
- With it: during each frame, miso shifts out MSB-first, changing on the synchronized sclk falling edge. The data is {4'b0, 12-bit value of the address received in the previous valid frame}. The source is the active output registers, and control reads {busy, enable}. miso = 0 while csn is high.
- Without it: miso is tied 0 and the readback mux and shift register are absent.

Decomposition:
Shared package aska_npg_pkg holds:
- register address constants ADDR_AMP through ADDR_CTRL;
- commit FSM state encodings CFG_IDLE, CFG_DIV, CFG_WAIT, CFG_LOAD;
- widths AMP_W = 6, FREQ_W = 12, RF_W = 10.

One sub-module is natural: aska_npg_rdiv, a 10-by-6-bit sequential restoring divider with start/done, which also implements the ramp_factor zero and clamp rules.

Test Plan:
- Reset -> freq = 400, phaseDuration = 1, all other outputs 0, busy = 0.
- Write amp = 40, ramp = 50, commit with pulse_active = 0 -> busy for 12 clk, then ramp_factor = 12 (640/50), amplitude = 40, enable set.
- Commit while pulse_active = 1 held for 30 clk -> outputs unchanged until the first clk after pulse_active falls, then update together in one cycle.
- 15-bit frame, then a frame to address 9 -> two cfg_err pulses, staging unchanged.
- amp = 1, ramp = 63 -> ramp_factor = 1; ramp = 0 -> ramp_factor = 0.
- During WAIT, write ctrl = 0 -> enable falls next clk; a second commit is rejected with cfg_err.
